alu_op_sequencer: RTL and testbench

- Front-end controller for the processor's arithmetic/logic resource.
- Accepts one operation at a time over a valid/ready request channel and sequences it: single-cycle ops run in one execute cycle, MUL runs iteratively for DATA_W cycles.
- Returns the result over a valid/ready response channel and maintains the 32-bit Condition Control Register (CCR) consumed by the branch logic.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_mul.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and CCR bit positions for the ALU op sequencer.
package alu_seq_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_MUL = 8;
  localparam int OP_INC = 9;
  localparam int OP_NOP = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int CCR_C    = 0;
  localparam int CCR_N    = 1;
  localparam int CCR_V    = 2;
  localparam int CCR_Z    = 3;
  localparam int CCR_INR  = 4;
  localparam int CCR_IFNR = 5;
  localparam int CCR_NOP  = 6;
  localparam int CCR_W    = 7;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative radix-2 shift-add multiplier: bit 0 is consumed on start, the
// remaining DATA_W-1 bits one per cycle; o_done flags a complete product.
module alu_seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);
  localparam int CW = $clog2(DATA_W);

  logic [2*DATA_W-1:0] r_prod;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplr;
  logic [CW-1:0]       r_cnt;
  logic                r_run;

  assign o_done    = r_run && (r_cnt == CW'(DATA_W - 1));
  assign o_product = r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_clear) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_start) begin
      r_prod  <= i_b[0] ? {{DATA_W{1'b0}}, i_a} : '0;
      r_mcand <= {{DATA_W{1'b0}}, i_a} << 1;
      r_mplr  <= i_b >> 1;
      r_cnt   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      if (o_done) begin
        r_run <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        if (r_mplr[0]) r_prod <= r_prod + r_mcand;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the ALU: request/response handshakes, op sequencing,
// result register and the Condition Control Register used by branch logic.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [OP_W-1:0]   Req_Op,
  input  logic [DATA_W-1:0] Req_A,
  input  logic [DATA_W-1:0] Req_B,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_Result,
  output logic [31:0]       CCR,
  output logic              Busy,
  output state_t            Dbg_State
);
  localparam int SHW = $clog2(DATA_W);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Req_Ready is high only in IDLE (not during reset or Flush); Rsp_Valid
  // holds with a stable result in RESP until Rsp_Ready, and Flush withdraws it.

  state_t              r_state, w_next_state;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_result;
  logic [CCR_W-1:0]    r_ccr, w_ccr;
  logic                w_accept, w_load, w_mul_start, w_mul_done, w_recog;
  logic [2*DATA_W-1:0] w_mul_prod;
  logic [DATA_W-1:0]   w_res, w_add_b;
  logic [DATA_W:0]     w_sum, w_shl, w_shr;
  logic [SHW-1:0]      w_sh;

  assign Req_Ready   = (r_state == S_IDLE) && Reset_n && !Flush;
  assign w_accept    = Req_Valid && Req_Ready;
  assign w_mul_start = w_accept && (Req_Op == OP_W'(OP_MUL));
  assign Rsp_Valid   = (r_state == S_RESP) && !Flush;
  assign Rsp_Result  = r_result;
  assign CCR         = {{(32 - CCR_W){1'b0}}, r_ccr};
  assign Busy        = (r_state != S_IDLE);
  assign Dbg_State   = r_state;

  alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .i_start   (w_mul_start),
    .i_clear   (Flush),
    .i_a       (Req_A),
    .i_b       (Req_B),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_mul_start ? S_MUL : S_EXEC;
      S_EXEC: begin
        w_next_state = S_RESP;
        w_load       = 1'b1;
      end
      S_MUL: if (w_mul_done) begin
        w_next_state = S_RESP;
        w_load       = 1'b1;
      end
      S_RESP: if (Rsp_Ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (Flush) begin
      w_next_state = S_IDLE;
      w_load       = 1'b0;
    end
  end

  // SUB and INC share the adder so carry and overflow fall out uniformly.
  assign w_sh    = r_b[SHW-1:0];
  assign w_add_b = (r_op == OP_W'(OP_SUB)) ? ~r_b :
                   (r_op == OP_W'(OP_INC)) ? DATA_W'(1) : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_add_b} + (DATA_W + 1)'(r_op == OP_W'(OP_SUB));
  assign w_shl   = {1'b0, r_a} << w_sh;
  assign w_shr   = {r_a, 1'b0} >> w_sh;

  always_comb begin
    w_res   = '0;
    w_ccr   = r_ccr;
    w_recog = 1'b1;
    case (r_op)
      OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_INC): begin
        w_res        = w_sum[DATA_W-1:0];
        w_ccr[CCR_C] = w_sum[DATA_W];
        w_ccr[CCR_V] = (r_a[DATA_W-1] == w_add_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_W'(OP_AND): w_res = r_a & r_b;
      OP_W'(OP_OR):  w_res = r_a | r_b;
      OP_W'(OP_XOR): w_res = r_a ^ r_b;
      OP_W'(OP_NOT): w_res = ~r_a;
      OP_W'(OP_SHL): begin
        w_res        = w_shl[DATA_W-1:0];
        w_ccr[CCR_C] = w_shl[DATA_W];
      end
      OP_W'(OP_SHR): begin
        w_res        = w_shr[DATA_W:1];
        w_ccr[CCR_C] = w_shr[0];
      end
      OP_W'(OP_MUL): begin
        w_res        = w_mul_prod[DATA_W-1:0];
        w_ccr[CCR_V] = |w_mul_prod[2*DATA_W-1:DATA_W];
      end
      OP_W'(OP_NOP): w_res = r_a;
      default:       w_recog = 1'b0;
    endcase
    if (r_op == OP_W'(OP_NOP)) begin
      w_ccr[CCR_NOP] = 1'b1;
    end else if (!w_recog) begin
      w_ccr[CCR_INR] = 1'b1;
      w_ccr[CCR_NOP] = 1'b0;
    end else begin
      w_ccr[CCR_N]   = w_res[DATA_W-1];
      w_ccr[CCR_Z]   = (w_res == '0);
      w_ccr[CCR_INR] = 1'b0;
      w_ccr[CCR_NOP] = 1'b0;
    end
    w_ccr[CCR_IFNR] = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ccr    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op <= Req_Op;
        r_a  <= Req_A;
        r_b  <= Req_B;
      end
      if (w_load) begin
        r_result <= w_res;
        r_ccr    <= w_ccr;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table of ops with hand-computed results
// and cumulative CCR values, plus hand-written backpressure, flush and reset sequences.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Flush = 1'b0;
  logic              Req_Valid = 1'b0;
  logic              Req_Ready;
  logic [OP_W-1:0]   Req_Op = '0;
  logic [DATA_W-1:0] Req_A = '0;
  logic [DATA_W-1:0] Req_B = '0;
  logic              Rsp_Valid;
  logic              Rsp_Ready = 1'b0;
  logic [DATA_W-1:0] Rsp_Result;
  logic [31:0]       CCR;
  logic              Busy;
  state_t            Dbg_State;

  alu_op_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Flush      (Flush),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Op     (Req_Op),
    .Req_A      (Req_A),
    .Req_B      (Req_B),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Result (Rsp_Result),
    .CCR        (CCR),
    .Busy       (Busy),
    .Dbg_State  (Dbg_State)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] ccr;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] ccr, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.ccr = ccr; v.lat = lat;
    vecs.push_back(v);
  endtask

  // driver: issue one op with Rsp_Ready held high, return the response and latency
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] ccr, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge Clock);
    check("req_ready_idle", Req_Ready, 1);
    Req_Valid = 1'b1; Req_Op = op; Req_A = a; Req_B = b; Rsp_Ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    lat = 0;
    do begin
      if (!(Busy === 1'b1 && Req_Ready === 1'b0)) busy_ok = 1'b0;
      @(posedge Clock);
      lat++;
      @(negedge Clock);
    end while (Rsp_Valid !== 1'b1 && lat < 100);
    res = Rsp_Result;
    ccr = CCR;
    check("busy_while_active", busy_ok, 1);
  endtask

  task automatic run_check(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eres,
                           input logic [31:0] eccr, input int elat);
    logic [31:0] res, ccr;
    int lat;
    run_op(op, a, b, res, ccr, lat);
    check({name, "_result"}, res, eres);
    check({name, "_ccr"}, ccr, eccr);
    check({name, "_latency"}, lat, elat);
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    report();
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable_ok;
    bit no_rsp;

    // reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_req_ready", Req_Ready, 0);
    check("rst_rsp_valid", Rsp_Valid, 0);
    check("rst_result", Rsp_Result, 0);
    check("rst_ccr", CCR, 0);
    check("rst_busy", Busy, 0);
    check("rst_state", Dbg_State, S_IDLE);
    Reset_n = 1'b1;
    #1 check("rel_req_ready", Req_Ready, 1);

    //       op     A             B             result        CCR    latency
    add_vec(4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h06, 1);
    add_vec(4'd1,  32'h5,        32'h5,        32'h0,        32'h09, 1);
    add_vec(4'd15, 32'h9,        32'h0,        32'h9,        32'h49, 1);
    add_vec(4'd12, 32'h3,        32'h4,        32'h0,        32'h19, 1);
    add_vec(4'd0,  32'h1,        32'h1,        32'h2,        32'h00, 1);
    add_vec(4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h03, 1);
    add_vec(4'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 32'h01, 1);
    add_vec(4'd3,  32'h80000000, 32'h1,        32'h80000001, 32'h03, 1);
    add_vec(4'd5,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h09, 1);
    add_vec(4'd6,  32'h80000001, 32'h1,        32'h2,        32'h01, 1);
    add_vec(4'd6,  32'h40000000, 32'h21,       32'h80000000, 32'h02, 1);
    add_vec(4'd7,  32'h3,        32'h1,        32'h1,        32'h01, 1);
    add_vec(4'd7,  32'h80000000, 32'h1F,       32'h1,        32'h00, 1);
    add_vec(4'd6,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h02, 1);
    add_vec(4'd1,  32'h3,        32'h5,        32'hFFFFFFFE, 32'h02, 1);
    add_vec(4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h05, 1);
    add_vec(4'd9,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h09, 1);
    add_vec(4'd9,  32'h7FFFFFFF, 32'h0,        32'h80000000, 32'h06, 1);
    add_vec(4'd8,  32'h3,        32'h5,        32'hF,        32'h00, 32);
    add_vec(4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h04, 32);
    add_vec(4'd8,  32'h00010000, 32'h00010000, 32'h0,        32'h0C, 32);
    add_vec(4'd8,  32'h0,        32'h1234,     32'h0,        32'h08, 32);
    add_vec(4'd14, 32'h5,        32'h6,        32'h0,        32'h18, 1);
    add_vec(4'd15, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h58, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_check($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].ccr, vecs[i].lat);
    end

    // backpressure: XOR held in RESP for 5 cycles while a new request is offered
    @(negedge Clock);
    Req_Valid = 1'b1; Req_Op = 4'd4; Req_A = 32'hF0F0F0F0; Req_B = 32'hFFFFFFFF; Rsp_Ready = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check("bp_valid", Rsp_Valid, 1);
    check("bp_result", Rsp_Result, 32'h0F0F0F0F);
    check("bp_ccr", CCR, 32'h00);
    Req_Valid = 1'b1; Req_Op = 4'd0; Req_A = 32'h1; Req_B = 32'h1;
    stable_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (!(Rsp_Valid === 1'b1 && Rsp_Result === 32'h0F0F0F0F && Req_Ready === 1'b0 &&
            Dbg_State === S_RESP)) stable_ok = 1'b0;
    end
    check("bp_stable", stable_ok, 1);
    Rsp_Ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    check("bp_idle_state", Dbg_State, S_IDLE);
    check("bp_idle_valid", Rsp_Valid, 0);

    // flush in IDLE blocks the accept
    @(negedge Clock);
    Flush = 1'b1; Req_Valid = 1'b1; Req_Op = 4'd0; Req_A = 32'h1; Req_B = 32'h1;
    #1 check("flush_idle_ready", Req_Ready, 0);
    @(posedge Clock);
    @(negedge Clock);
    check("flush_idle_busy", Busy, 0);
    Flush = 1'b0; Req_Valid = 1'b0;

    // flush at MUL cycle 10: no response, result and CCR untouched
    run_check("nop_pre_flush", 4'd15, 32'h12345678, 32'h0, 32'h12345678, 32'h40, 1);
    @(negedge Clock);
    Req_Valid = 1'b1; Req_Op = 4'd8; Req_A = 32'h3; Req_B = 32'h3;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    check("flush_mul_busy_before", Busy, 1);
    Flush = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Flush = 1'b0;
    check("flush_mul_state", Dbg_State, S_IDLE);
    check("flush_mul_valid", Rsp_Valid, 0);
    check("flush_mul_result", Rsp_Result, 32'h12345678);
    check("flush_mul_ccr", CCR, 32'h40);
    no_rsp = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (Rsp_Valid !== 1'b0 || Busy !== 1'b0) no_rsp = 1'b0;
    end
    check("flush_mul_quiet", no_rsp, 1);
    run_check("mul_after_flush", 4'd8, 32'h6, 32'h7, 32'h2A, 32'h00, 32);

    // flush in RESP withdraws the response
    @(negedge Clock);
    Req_Valid = 1'b1; Req_Op = 4'd0; Req_A = 32'h2; Req_B = 32'h3; Rsp_Ready = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check("flush_resp_valid_before", Rsp_Valid, 1);
    Flush = 1'b1;
    #1 check("flush_resp_valid_during", Rsp_Valid, 0);
    @(posedge Clock);
    @(negedge Clock);
    Flush = 1'b0;
    Rsp_Ready = 1'b1;
    check("flush_resp_busy", Busy, 0);
    check("flush_resp_result", Rsp_Result, 32'h5);

    // reset mid-MUL clears every output at once
    run_check("nop_pre_reset", 4'd15, 32'h77, 32'h0, 32'h77, 32'h40, 1);
    @(negedge Clock);
    Req_Valid = 1'b1; Req_Op = 4'd8; Req_A = 32'hFFFFFFFF; Req_B = 32'hFFFFFFFF;
    @(posedge Clock);
    @(negedge Clock);
    Req_Valid = 1'b0;
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_busy", Busy, 0);
    check("rst_mid_ready", Req_Ready, 0);
    check("rst_mid_valid", Rsp_Valid, 0);
    check("rst_mid_result", Rsp_Result, 0);
    check("rst_mid_ccr", CCR, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1 check("rst_mid_rel_ready", Req_Ready, 1);
    run_check("mul_after_reset", 4'd8, 32'h3, 32'h5, 32'hF, 32'h00, 32);

    report();
    $finish;
  end

endmodule
